// File: rtl/uart_mmio_peripheral.sv
// UART peripheral for the CPU's MMIO UART window: TX/RX FIFOs plus 8N1 serializer/deserializer.
// Define UART_PARITY_EN to add an even-parity bit to both directions (11-bit frames).
module uart_mmio_peripheral #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wen,
    input  logic [7:0] uart_din,
    input  logic       rx_ren,
    output logic [7:0] uart_dout,
    output logic       rx_data_present,
    output logic       tx_full,
    input  logic       rxd,
    output logic       txd
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [AW:0]   tx_count;
    logic          tx_push, tx_pop;

    assign tx_full = (tx_count == FULL_CNT);
    assign tx_push = tx_wen && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= uart_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_done, txd_next;
`ifdef UART_PARITY_EN
    logic          tx_par;
`endif

    assign tx_bit_done = (tx_cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_next;
            txd      <= txd_next;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rd_ptr];
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_mem[tx_rd_ptr];
`endif
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_done) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_count != '0) tx_next = TX_START;
            TX_START: if (tx_bit_done) tx_next = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_bit_done && tx_bit == 3'd7) tx_next = TX_PARITY;
            TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
`else
            TX_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = TX_STOP;
`endif
            TX_STOP:  if (tx_bit_done) tx_next = (tx_count != '0) ? TX_START : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // txd is registered from the state, so the line lags the state by one cycle
    always_comb begin
        tx_pop   = (tx_count != '0) &&
                   (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_done));
        txd_next = 1'b1;
        case (tx_state)
            TX_START:  txd_next = 1'b0;
            TX_DATA:   txd_next = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: txd_next = tx_par;
`endif
            default:   txd_next = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_t     rx_state, rx_next;
    logic          rxd_s1, rxd_s2, rxd_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_bit_done, rx_push_req, rx_push, rx_pop;
`ifdef UART_PARITY_EN
    logic          rx_par_ok;
`endif

    assign rx_bit_done = (rx_cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1    <= 1'b1;
            rxd_s2    <= 1'b1;
            rxd_prev  <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
`ifdef UART_PARITY_EN
            rx_par_ok <= 1'b0;
`endif
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            rx_state <= rx_next;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= (rx_cnt == HALF_END) ? '0 : rx_cnt + 1'b1;
                default: begin
                    if (rx_bit_done) begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rxd_s2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 1'b1;
                        end
`ifdef UART_PARITY_EN
                        if (rx_state == RX_PARITY) rx_par_ok <= (rxd_s2 == ^rx_shift);
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rxd_prev && !rxd_s2) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_END) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:   if (rx_bit_done && rx_bit == 3'd7) rx_next = RX_PARITY;
            RX_PARITY: if (rx_bit_done) rx_next = RX_STOP;
`else
            RX_DATA:  if (rx_bit_done && rx_bit == 3'd7) rx_next = RX_STOP;
`endif
            RX_STOP:  if (rx_bit_done) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
`ifdef UART_PARITY_EN
        rx_push_req = (rx_state == RX_STOP) && rx_bit_done && rxd_s2 && rx_par_ok;
`else
        rx_push_req = (rx_state == RX_STOP) && rx_bit_done && rxd_s2;
`endif
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [AW:0]   rx_count;

    assign rx_push         = rx_push_req && (rx_count != FULL_CNT);
    assign rx_pop          = rx_ren && (rx_count != '0);
    assign rx_data_present = (rx_count != '0);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            uart_dout <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_ren)  uart_dout <= rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Directed self-checking bench for uart_mmio_peripheral with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_mmio_peripheral;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wen = 1'b0;
    logic [7:0] uart_din = 8'h00;
    logic       rx_ren = 1'b0;
    logic [7:0] uart_dout;
    logic       rx_data_present;
    logic       tx_full;
    logic       rxd = 1'b1;
    logic       txd;

    int checks = 0;
    int passed = 0;

    uart_mmio_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .tx_wen(tx_wen), .uart_din(uart_din),
        .rx_ren(rx_ren), .uart_dout(uart_dout), .rx_data_present(rx_data_present),
        .tx_full(tx_full), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    // All tasks start and end one time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wen = 1'b1;
        uart_din = b;
        step(1);
        tx_wen = 1'b0;
    endtask

    task automatic read_rx();
        rx_ren = 1'b1;
        step(1);
        rx_ren = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        rxd = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(CPB);
        end
`ifdef UART_PARITY_EN
        rxd = par_bit;
        step(CPB);
`endif
        rxd = stop_bit;
        step(CPB);
        rxd = 1'b1;
    endtask

    // Waits up to max_wait cycles for a start bit, then checks every cycle of the frame.
    task automatic tx_frame(input logic [7:0] b, input int max_wait, input string name);
        logic [10:0] bits;
        int w;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_PARITY_EN
        bits[9] = ^b;
`endif
        w = 0;
        while (txd !== 1'b0 && w < max_wait) begin
            step(1);
            w++;
        end
        checks++;
        if (txd !== 1'b0) begin
            $display("FAIL %s start: txd=%b required 0 within %0d cycles", name, txd, max_wait);
            return;
        end
        passed++;
        for (int j = 0; j < NB; j++) begin
            for (int c = 0; c < CPB; c++) begin
                checks++;
                if (txd !== bits[j])
                    $display("FAIL %s bit%0d cyc%0d: txd=%b required %b", name, j, c, txd, bits[j]);
                else
                    passed++;
                step(1);
            end
        end
    endtask

    task automatic wait_rx_present(input int max_wait, input string name);
        int w;
        w = 0;
        while (rx_data_present !== 1'b1 && w < max_wait) begin
            step(1);
            w++;
        end
        checks++;
        if (rx_data_present !== 1'b1)
            $display("FAIL %s: rx_data_present=%b required 1 within %0d cycles", name, rx_data_present, max_wait);
        else
            passed++;
    endtask

    task automatic test_reset();
        step(3);
        checks++; if (txd !== 1'b1) $display("FAIL reset txd: %b required 1", txd); else passed++;
        checks++; if (uart_dout !== 8'h00) $display("FAIL reset dout: %h required 00", uart_dout); else passed++;
        checks++; if (rx_data_present !== 1'b0) $display("FAIL reset rxp: %b required 0", rx_data_present); else passed++;
        checks++; if (tx_full !== 1'b0) $display("FAIL reset full: %b required 0", tx_full); else passed++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_tx_basic();
        push_tx(8'hA5);
        checks++; if (txd !== 1'b1) $display("FAIL tx latency N: txd=%b required 1", txd); else passed++;
        step(1);
        checks++; if (txd !== 1'b1) $display("FAIL tx latency N+1: txd=%b required 1", txd); else passed++;
        step(1);
        tx_frame(8'hA5, 0, "tx_a5");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (txd !== 1'b1) $display("FAIL tx idle after a5: txd=%b required 1", txd); else passed++;
            step(1);
        end
    endtask

    task automatic test_tx_full();
        int w;
        // 0xFF occupies the transmitter while 0x00..0x10 are pushed
        for (int j = 0; j < 18; j++) begin
            tx_wen = 1'b1;
            uart_din = (j == 0) ? 8'hFF : 8'(j - 1);
            if (j == 17) begin
                checks++;
                if (tx_full !== 1'b1) $display("FAIL tx_full after 16th push: %b required 1", tx_full); else passed++;
            end
            step(1);
        end
        tx_wen = 1'b0;
        checks++;
        if (tx_full !== 1'b1) $display("FAIL tx_full after dropped push: %b required 1", tx_full); else passed++;
        w = 0;
        while (tx_full !== 1'b0 && w < 80) begin
            step(1);
            w++;
        end
        checks++;
        if (tx_full !== 1'b0) $display("FAIL tx_full release: %b required 0", tx_full); else passed++;
        tx_frame(8'h00, 2, "tx_fifo_0");
        for (int i = 1; i < 16; i++) tx_frame(8'(i), 0, "tx_fifo_b2b");
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (txd !== 1'b1) $display("FAIL tx dropped byte sent: txd=%b required 1", txd); else passed++;
            step(1);
        end
    endtask

    task automatic test_rx_read();
        rx_send(8'h3C, 1'b1, ^8'h3C);
        wait_rx_present(2, "rx_3c present");
        read_rx();
        checks++; if (uart_dout !== 8'h3C) $display("FAIL rx_3c dout: %h required 3c", uart_dout); else passed++;
        checks++; if (rx_data_present !== 1'b0) $display("FAIL rx_3c after pop: %b required 0", rx_data_present); else passed++;
        step(5);
        checks++; if (uart_dout !== 8'h3C) $display("FAIL rx dout hold: %h required 3c", uart_dout); else passed++;
    endtask

    task automatic test_rx_errors();
        rx_send(8'h55, 1'b0, ^8'h55);
        step(8);
        checks++; if (rx_data_present !== 1'b0) $display("FAIL rx framing err stored: %b required 0", rx_data_present); else passed++;
        rxd = 1'b0;
        step(1);
        rxd = 1'b1;
        step(20);
        checks++; if (rx_data_present !== 1'b0) $display("FAIL rx glitch stored: %b required 0", rx_data_present); else passed++;
        read_rx();
        checks++; if (uart_dout !== 8'h00) $display("FAIL rx empty read: %h required 00", uart_dout); else passed++;
        rx_send(8'hC3, 1'b1, ^8'hC3);
        wait_rx_present(2, "rx_c3 present");
        read_rx();
        checks++; if (uart_dout !== 8'hC3) $display("FAIL rx_c3 dout: %h required c3", uart_dout); else passed++;
    endtask

    task automatic test_back_to_back();
        rx_send(8'h11, 1'b1, ^8'h11);
        rx_send(8'h22, 1'b1, ^8'h22);
        step(4);
        read_rx();
        checks++; if (uart_dout !== 8'h11) $display("FAIL rx b2b first: %h required 11", uart_dout); else passed++;
        checks++; if (rx_data_present !== 1'b1) $display("FAIL rx b2b still present: %b required 1", rx_data_present); else passed++;
        read_rx();
        checks++; if (uart_dout !== 8'h22) $display("FAIL rx b2b second: %h required 22", uart_dout); else passed++;
        checks++; if (rx_data_present !== 1'b0) $display("FAIL rx b2b drained: %b required 0", rx_data_present); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        push_tx(8'h96);
        rxd = 1'b0;
        step(10);
        rst = 1'b1;
        rxd = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (txd !== 1'b1) $display("FAIL midreset txd: %b required 1", txd); else passed++;
        checks++; if (rx_data_present !== 1'b0) $display("FAIL midreset rxp: %b required 0", rx_data_present); else passed++;
        checks++; if (tx_full !== 1'b0) $display("FAIL midreset full: %b required 0", tx_full); else passed++;
        step(6);
        checks++; if (txd !== 1'b1) $display("FAIL midreset tx resumed: txd=%b required 1", txd); else passed++;
        push_tx(8'h69);
        tx_frame(8'h69, 3, "tx_after_reset");
        rx_send(8'hA6, 1'b1, ^8'hA6);
        wait_rx_present(2, "rx_after_reset present");
        read_rx();
        checks++; if (uart_dout !== 8'hA6) $display("FAIL rx after reset: %h required a6", uart_dout); else passed++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        push_tx(8'h07);
        tx_frame(8'h07, 3, "tx_parity_07");
        rx_send(8'h07, 1'b1, 1'b0);
        step(8);
        checks++; if (rx_data_present !== 1'b0) $display("FAIL rx parity err stored: %b required 0", rx_data_present); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_rx_read();
        test_rx_errors();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
